// File: rtl/calc2_pkg.sv
// Shared types and the arithmetic kernel for the calc2 request/response port.
package calc2_pkg;

   typedef enum logic [3:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_OK   = 2'd1,
      RESP_ERR  = 2'd2
   } resp_e;

   typedef logic [1:0] tag_t;

   localparam int NUM_TAGS = 4;

   // cmd is kept as raw bits so invalid opcodes survive to the response stage.
   typedef struct packed {
      logic [3:0]  cmd;
      logic [31:0] op1;
      logic [31:0] op2;
      tag_t        tag;
      logic        dup;
   } job_t;

   typedef struct packed {
      resp_e       resp;
      logic [31:0] data;
      tag_t        tag;
   } rsp_t;

   // A duplicate never owns its tag bit, so its response must not clear it.
   typedef struct packed {
      rsp_t        rsp;
      logic        owns_tag;
   } ent_t;

   function automatic logic is_shift(input logic [3:0] cmd);
      return (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction

   function automatic ent_t exec_job(input job_t j);
      ent_t        e;
      logic [32:0] sum;
      e.rsp.resp = RESP_ERR;
      e.rsp.data = '0;
      e.rsp.tag  = j.tag;
      e.owns_tag = !j.dup;
      sum        = {1'b0, j.op1} + {1'b0, j.op2};
      if (!j.dup) begin
         case (j.cmd)
            CMD_ADD: begin
               if (!sum[32]) begin
                  e.rsp.resp = RESP_OK;
                  e.rsp.data = sum[31:0];
               end
            end
            CMD_SUB: begin
               if (j.op2 <= j.op1) begin
                  e.rsp.resp = RESP_OK;
                  e.rsp.data = j.op1 - j.op2;
               end
            end
            CMD_SHL: begin
               e.rsp.resp = RESP_OK;
               e.rsp.data = j.op1 << j.op2[4:0];
            end
            CMD_SHR: begin
               e.rsp.resp = RESP_OK;
               e.rsp.data = j.op1 >> j.op2[4:0];
            end
            default: ;
         endcase
      end
      return e;
   endfunction

endpackage

// File: rtl/calc2_resp_fifo.sv
// Response queue with two push ports (port a is the older result) and one pop.
// Pushes that find no room are refused and reported on drop_a/drop_b.
module calc2_resp_fifo
   import calc2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_a,
   input  ent_t data_a,
   input  logic push_b,
   input  ent_t data_b,
   input  logic pop,
   output ent_t head,
   output logic full,
   output logic empty,
   output logic drop_a,
   output logic drop_b
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ent_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          do_pop;
   logic          acc_a;
   logic          acc_b;
   logic [CW-1:0] space;
   logic [1:0]    n_push;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign head   = mem[rd_ptr];
   assign do_pop = pop && !empty;

   // A same-cycle pop frees one slot for the incoming results.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      space  = CW'(DEPTH) - count + CW'(do_pop);
      acc_a  = 1'b0;
      acc_b  = 1'b0;
      if (push_a && space != '0) acc_a = 1'b1;
      if (push_b && space > CW'(acc_a)) acc_b = 1'b1;
      n_push = {1'b0, acc_a} + {1'b0, acc_b};
      drop_a = push_a && !acc_a;
      drop_b = push_b && !acc_b;
   end

   // NOTE: storage is not reset; only the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (acc_a) mem[wr_ptr] <= data_a;
      if (acc_b) mem[wr_ptr + AW'(acc_a)] <= data_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(n_push);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count  <= count + CW'(n_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/calc2_port_responder.sv
// One calc2 port: two-cycle command capture, add/sub and shift pipes of
// different depths, a response queue and one-cycle tagged responses.
module calc2_port_responder
   import calc2_pkg::*;
#(
   parameter int ADD_LAT   = 2,
   parameter int SHIFT_LAT = 4,
   parameter int RQ_DEPTH  = 4
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [3:0]  req_cmd_in,
   input  logic [31:0] req_data_in,
   input  logic [1:0]  req_tag_in,
   output logic [1:0]  out_resp,
   output logic [31:0] out_data,
   output logic [1:0]  out_tag,
   output logic        err_o
);

   // With distinct latencies the deeper pipe always holds the older job on a tie.
   localparam bit SHIFT_OLDER = (SHIFT_LAT > ADD_LAT);

   typedef enum logic {ST_IDLE, ST_OP2} state_e;

   state_e              state;
   logic [3:0]          cmd_q;
   logic [31:0]         op1_q;
   tag_t                tag_q;
   logic [NUM_TAGS-1:0] inflight;

   job_t                job;
   ent_t                job_res;
   logic                dispatch;
   logic                to_shift;
   logic                to_add;

   logic                add_v [ADD_LAT];
   ent_t                add_q [ADD_LAT];
   logic                sh_v  [SHIFT_LAT];
   ent_t                sh_q  [SHIFT_LAT];

   logic                push_a, push_b;
   ent_t                data_a, data_b;
   ent_t                head;
   logic                q_full, q_empty;
   logic                drop_a, drop_b;
   logic                pop;
   logic [NUM_TAGS-1:0] set_vec, clr_vec;

   // The operand2 cycle is the dispatch cycle; req_cmd_in is not looked at here.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cmd_q <= '0;
         op1_q <= '0;
         tag_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         case (state)
            ST_IDLE: begin
               if (req_cmd_in != CMD_NOP) begin
                  cmd_q <= req_cmd_in;
                  op1_q <= req_data_in;
                  tag_q <= req_tag_in;
                  state <= ST_OP2;
               end
            end
            ST_OP2:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign dispatch = (state == ST_OP2);

   always_comb begin
      job.cmd = cmd_q;
      job.op1 = op1_q;
      job.op2 = req_data_in;
      job.tag = tag_q;
      job.dup = inflight[tag_q];
   end

   assign job_res  = exec_job(job);
   assign to_shift = dispatch && !job.dup && is_shift(cmd_q);
   assign to_add   = dispatch && !to_shift;

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ADD_LAT; i++) begin
            add_v[i] <= 1'b0;
            add_q[i] <= '0;
         end
      end else begin
         add_v[0] <= to_add;
         add_q[0] <= job_res;
         for (int i = 1; i < ADD_LAT; i++) begin
            add_v[i] <= add_v[i-1];
            add_q[i] <= add_q[i-1];
         end
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SHIFT_LAT; i++) begin
            sh_v[i] <= 1'b0;
            sh_q[i] <= '0;
         end
      end else begin
         sh_v[0] <= to_shift;
         sh_q[0] <= job_res;
         for (int i = 1; i < SHIFT_LAT; i++) begin
            sh_v[i] <= sh_v[i-1];
            sh_q[i] <= sh_q[i-1];
         end
      end
   end

   assign push_a = SHIFT_OLDER ? sh_v[SHIFT_LAT-1] : add_v[ADD_LAT-1];
   assign data_a = SHIFT_OLDER ? sh_q[SHIFT_LAT-1] : add_q[ADD_LAT-1];
   assign push_b = SHIFT_OLDER ? add_v[ADD_LAT-1] : sh_v[SHIFT_LAT-1];
   assign data_b = SHIFT_OLDER ? add_q[ADD_LAT-1] : sh_q[SHIFT_LAT-1];

   calc2_resp_fifo #(
      .DEPTH (RQ_DEPTH)
   ) u_fifo (
      .clk    (c_clk),
      .rst_n  (reset),
      .push_a (push_a),
      .data_a (data_a),
      .push_b (push_b),
      .data_b (data_b),
      .pop    (pop),
      .head   (head),
      .full   (q_full),
      .empty  (q_empty),
      .drop_a (drop_a),
      .drop_b (drop_b)
   );

   assign pop = !q_empty;

   // Tag bits are released when the response is driven or when the result is dropped.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (dispatch && !job.dup) set_vec[tag_q] = 1'b1;
      if (pop && head.owns_tag) clr_vec[head.rsp.tag] = 1'b1;
      if (drop_a && data_a.owns_tag) clr_vec[data_a.rsp.tag] = 1'b1;
      if (drop_b && data_b.owns_tag) clr_vec[data_b.rsp.tag] = 1'b1;
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         out_resp <= '0;
         out_data <= '0;
         out_tag  <= '0;
         err_o    <= 1'b0;
         inflight <= '0;
      end else begin
         if (pop) begin
            out_resp <= head.rsp.resp;
            out_data <= head.rsp.data;
            out_tag  <= head.rsp.tag;
         end else begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
         end
         inflight <= (inflight & ~clr_vec) | set_vec;
         if (drop_a || drop_b) err_o <= 1'b1;
      end
   end

   a_resp_legal: assert property (@(posedge c_clk) disable iff (!reset)
      out_resp != 2'd3);

   a_data_zero: assert property (@(posedge c_clk) disable iff (!reset)
      (out_resp != RESP_OK) |-> (out_data == '0));

endmodule

// File: tb/tb_calc2_port_responder.sv
// Directed bench for calc2_port_responder: hand-computed responses, latency,
// completion ordering, duplicate tags and mid-operation reset.
module tb_calc2_port_responder;

   localparam int ADD_LAT   = 2;
   localparam int SHIFT_LAT = 4;

   logic        c_clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req_cmd_in  = '0;
   logic [31:0] req_data_in = '0;
   logic [1:0]  req_tag_in  = '0;
   logic [1:0]  out_resp;
   logic [31:0] out_data;
   logic [1:0]  out_tag;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   calc2_port_responder #(
      .ADD_LAT   (ADD_LAT),
      .SHIFT_LAT (SHIFT_LAT),
      .RQ_DEPTH  (4)
   ) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .req_tag_in  (req_tag_in),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .err_o       (err_o)
   );

   always #5 c_clk = ~c_clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic expect_rsp(input string name, input logic [1:0] resp,
                             input logic [31:0] data, input logic [1:0] tag);
      check({name, "_resp"}, 32'(out_resp), 32'(resp));
      check({name, "_data"}, out_data, data);
      check({name, "_tag"},  32'(out_tag), 32'(tag));
   endtask

   task automatic expect_idle(input string name);
      check({name, "_resp"}, 32'(out_resp), 32'd0);
      check({name, "_data"}, out_data, 32'd0);
      check({name, "_tag"},  32'(out_tag), 32'd0);
   endtask

   // Returns just before the operand2 edge (k); the next negedge follows edge k.
   task automatic send(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [1:0] tag, input bit hold_cmd);
      @(negedge c_clk);
      req_cmd_in  = cmd;
      req_data_in = op1;
      req_tag_in  = tag;
      @(negedge c_clk);
      req_cmd_in  = hold_cmd ? cmd : 4'd0;
      req_data_in = op2;
      req_tag_in  = hold_cmd ? tag : 2'd0;
   endtask

   // Response expected after edge k+lat+1, held exactly one cycle.
   task automatic run_one(input string name, input logic [3:0] cmd, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [1:0] tag, input int lat,
                          input bit hold_cmd, input logic [1:0] eresp, input logic [31:0] edata);
      send(cmd, op1, op2, tag, hold_cmd);
      for (int j = 0; j <= lat + 3; j++) begin
         @(negedge c_clk);
         if (j == 0) begin
            req_cmd_in  = '0;
            req_data_in = '0;
            req_tag_in  = '0;
         end
         if (j == lat)     expect_idle({name, "_pre"});
         if (j == lat + 1) expect_rsp(name, eresp, edata, tag);
         if (j == lat + 2) expect_idle({name, "_post"});
         if (j == lat + 3) check({name, "_extra"}, 32'(out_resp), 32'd0);
      end
   endtask

   initial begin
      repeat (3) @(negedge c_clk);
      expect_idle("reset");
      check("reset_err", 32'(err_o), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge c_clk);

      run_one("add_basic", 4'd1, 32'h30,        32'h20, 2'd1, ADD_LAT,   1'b1, 2'd1, 32'h50);
      run_one("add_ovf",   4'd1, 32'hFFFF_FFFF, 32'h1,  2'd2, ADD_LAT,   1'b0, 2'd2, 32'h0);
      run_one("add_max",   4'd1, 32'hFFFF_FFFF, 32'h0,  2'd0, ADD_LAT,   1'b0, 2'd1, 32'hFFFF_FFFF);
      run_one("sub_unf",   4'd2, 32'd5,         32'd6,  2'd3, ADD_LAT,   1'b0, 2'd2, 32'h0);
      run_one("sub_ok",    4'd2, 32'd6,         32'd5,  2'd0, ADD_LAT,   1'b0, 2'd1, 32'h1);
      run_one("sub_eq",    4'd2, 32'd7,         32'd7,  2'd1, ADD_LAT,   1'b0, 2'd1, 32'h0);
      run_one("shl_amt",   4'd5, 32'h1,         32'h24, 2'd1, SHIFT_LAT, 1'b0, 2'd1, 32'h10);
      run_one("shr_31",    4'd6, 32'h8000_0000, 32'd31, 2'd2, SHIFT_LAT, 1'b0, 2'd1, 32'h1);
      run_one("shr_zero",  4'd6, 32'hF0,        32'h20, 2'd3, SHIFT_LAT, 1'b1, 2'd1, 32'hF0);
      run_one("shl_out",   4'd5, 32'hF000_0001, 32'd4,  2'd0, SHIFT_LAT, 1'b0, 2'd1, 32'h10);
      run_one("inv_3",     4'd3, 32'd1,         32'd2,  2'd2, ADD_LAT,   1'b0, 2'd2, 32'h0);
      run_one("inv_15",    4'd15, 32'd1,        32'd2,  2'd3, ADD_LAT,   1'b0, 2'd2, 32'h0);

      // shl at k and add at k+2 both finish at k+4; the shift result goes first.
      send(4'd5, 32'h1, 32'd3, 2'd0, 1'b0);
      send(4'd1, 32'h100, 32'h23, 2'd1, 1'b0);
      for (int j = 2; j <= 7; j++) begin
         @(negedge c_clk);
         if (j == 2) begin
            req_data_in = '0;
         end
         if (j == 4) expect_idle("tie_pre");
         if (j == 5) expect_rsp("tie_shl", 2'd1, 32'h8, 2'd0);
         if (j == 6) expect_rsp("tie_add", 2'd1, 32'h123, 2'd1);
         if (j == 7) expect_idle("tie_post");
      end

      // Second tag-1 request while the first is in flight.
      send(4'd1, 32'd7, 32'd8, 2'd1, 1'b0);
      send(4'd1, 32'd1, 32'd1, 2'd1, 1'b0);
      for (int j = 2; j <= 6; j++) begin
         @(negedge c_clk);
         if (j == 2) begin
            req_data_in = '0;
         end
         if (j == 3) expect_rsp("dup_orig", 2'd1, 32'd15, 2'd1);
         if (j == 4) expect_idle("dup_gap");
         if (j == 5) expect_rsp("dup_err", 2'd2, 32'h0, 2'd1);
         if (j == 6) expect_idle("dup_post");
      end
      run_one("tag_reuse", 4'd1, 32'd2, 32'd3, 2'd1, ADD_LAT, 1'b0, 2'd1, 32'd5);

      // Reset with a request waiting for operand2 and two jobs in the pipes.
      send(4'd5, 32'h1, 32'd1, 2'd0, 1'b0);
      send(4'd1, 32'd2, 32'd2, 2'd2, 1'b0);
      @(negedge c_clk);
      req_cmd_in  = 4'd1;
      req_data_in = 32'd9;
      req_tag_in  = 2'd3;
      @(posedge c_clk);
      #2;
      reset = 1'b0;
      #1;
      expect_idle("rst_mid");
      check("rst_mid_err", 32'(err_o), 32'd0);
      @(negedge c_clk);
      req_cmd_in  = '0;
      req_data_in = '0;
      req_tag_in  = '0;
      repeat (2) @(negedge c_clk);
      reset = 1'b1;
      for (int j = 0; j < 10; j++) begin
         @(negedge c_clk);
         check($sformatf("rst_quiet_%0d", j), 32'(out_resp), 32'd0);
      end
      run_one("post_rst", 4'd1, 32'd1, 32'd1, 2'd1, ADD_LAT, 1'b0, 2'd1, 32'd2);

      check("final_err", 32'(err_o), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc2_port_responder.md
Name: calc2_port_responder

Overview:
- Single-port responder for the calc2 request/response protocol.
- Accepts two-cycle tagged commands on one request port, executes add, sub, shift-left and shift-right in latency-mismatched pipes, and returns tagged responses.
- One instance per port; calc2_top-style integrations instantiate four of these behind a common clock/reset.

Parameters:
- ADD_LAT, 2, register stages in add/sub pipe (>=1).
- SHIFT_LAT, 4, register stages in shift pipe (>=1).
- RQ_DEPTH, 4, response queue entries (power of 2).

Ports:
- c_clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0, clears all state immediately.
- req_cmd_in  in  4  0 idle; 1 add; 2 sub; 5 shl; 6 shr; others invalid.
- req_data_in  in  32  operand1 in the cmd cycle, operand2 in the following cycle.
- req_tag_in  in  2  request tag, sampled in the cmd cycle.
- out_resp  out  2  0 none; 1 success; 2 overflow/underflow/invalid/duplicate tag; 3 never driven.
- out_data  out  32  result; 0 whenever out_resp != 1.
- out_tag  out  2  tag of the response; 0 when out_resp = 0.
- err_o  out  1  sticky response-queue overflow flag.

Behaviour:
- Reset (reset=0): FSM to IDLE, both pipes and queue flushed, in-flight tag bitmap cleared. out_resp=0, out_data=0, out_tag=0, err_o=0. Reset mid-operation discards all outstanding work with no response.
- Capture FSM, IDLE:
  - cmd!=0 at an edge: latch cmd, operand1 and tag, go to OP2.
  - cmd=0: stay in IDLE.
- Capture FSM, OP2:
  - At the next edge, latch operand2 (req_cmd_in ignored), dispatch the job, return to IDLE.
  - A cmd presented in the OP2 cycle is never treated as a new request.
- Dispatch:
  - Cmds 1 and 2, invalid cmds and duplicate-tag requests go to the add pipe (ADD_LAT).
  - Cmds 5 and 6 go to the shift pipe (SHIFT_LAT).
- Arithmetic:
  - add: 33-bit sum; carry out gives resp 2, data 0.
  - sub: operand2 > operand1 (unsigned) gives resp 2, data 0; otherwise resp 1, data op1-op2.
  - shl/shr: logical shift by operand2[4:0]; always resp 1; bits shifted out are discarded.
- Invalid cmd (not 1, 2, 5 or 6): resp 2, data 0.
- Duplicate tag: if the tag's bit is already set in the in-flight bitmap at dispatch, the job is marked duplicate: resp 2, data 0, original job unaffected. The bitmap bit is set at dispatch and cleared when that job's response is driven.
- Completion: a job leaving its pipe at edge k+LAT (k = operand2 edge) pushes into the response queue.
  - Both pipes completing at the same edge: push the older dispatch first.
- Output:
  - Queue pops one entry per cycle into the out_* registers. With an empty queue, the response is visible one cycle after the push: add visible after edge k+ADD_LAT+1.
  - Each response is held exactly one cycle; out_* return to 0 when the queue is empty.
- Queue full with a push pending: the new result is dropped, err_o is set until reset, and its tag bit is cleared. Unreachable at defaults (<=1 dispatch per 2 cycles), so this path is covered by assertion only.
- Assertions: out_resp never 3; out_data=0 whenever out_resp!=1.

Decomposition:
- Shared package calc2_pkg holds:
  - cmd_e enum (CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6).
  - resp_e enum (RESP_NONE=0, RESP_OK=1, RESP_ERR=2).
  - tag_t (2 bits).
  - job_t struct: cmd, op1, op2, tag, dup.
  - rsp_t struct: resp, data, tag.
- One sub-module, calc2_resp_fifo: parameterized RQ_DEPTH queue with a dual-push port (older push first), single pop, full/empty.

Test Plan:
- add 0x30 then 0x20, tag 1 -> resp 1, data 0x50, tag 1, visible 3 edges after the operand2 edge, held 1 cycle.
- add 0xFFFFFFFF + 0x1, tag 2 -> resp 2, data 0; sub 5 - 6, tag 3 -> resp 2, data 0; sub 6 - 5 -> resp 1, data 1.
- shl 0x1 by 0x24 (amount 4) -> resp 1, data 0x10; shr 0x80000000 by 31 -> data 0x1; response 5 edges after operand2.
- shl tag 0 dispatched at k, add tag 1 dispatched at k+2 -> both complete at k+4; shl response (tag 0) at k+5, add (tag 1) at k+6.
- cmd 3, tag 2 -> resp 2, data 0; second request with tag 1 while tag 1 is in flight -> resp 2 for the duplicate, original returns resp 1 with its correct data.
- reset=0 while OP2 pending and two jobs in pipes -> all outputs 0 immediately, no responses after release, next add 1+1 returns data 2.
